// File: rtl/wb_ram_arbiter.sv
// Round-robin Wishbone B3 arbiter: several masters share one RAM slave port.
// A grant is taken in IDLE and held in BUSY until the granted master drops cyc.
// A per-transfer watchdog returns an error to the granted master when the slave
// stays silent for TIMEOUT strobed cycles.
module wb_ram_arbiter #(
  parameter int NUM_MASTERS = 3,
  parameter int aw          = 32,
  parameter int dw          = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  // master side
  input  logic [NUM_MASTERS*aw-1:0] wbm_adr_i,
  input  logic [NUM_MASTERS*dw-1:0] wbm_dat_i,
  input  logic [NUM_MASTERS*4-1:0]  wbm_sel_i,
  input  logic [NUM_MASTERS-1:0]    wbm_we_i,
  input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
  input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
  input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
  input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
  output logic [dw-1:0]             wbm_dat_o,
  output logic [NUM_MASTERS-1:0]    wbm_ack_o,
  output logic [NUM_MASTERS-1:0]    wbm_err_o,
  output logic [NUM_MASTERS-1:0]    wbm_rty_o,
  // slave side
  output logic [aw-1:0]             wbs_adr_o,
  output logic [dw-1:0]             wbs_dat_o,
  output logic [3:0]                wbs_sel_o,
  output logic                      wbs_we_o,
  output logic                      wbs_cyc_o,
  output logic                      wbs_stb_o,
  output logic [2:0]                wbs_cti_o,
  output logic [1:0]                wbs_bte_o,
  input  logic [dw-1:0]             wbs_dat_i,
  input  logic                      wbs_ack_i,
  input  logic                      wbs_err_i,
  input  logic                      wbs_rty_i,
  // arbitration status
  output logic [NUM_MASTERS-1:0]    grant_o
);

  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [IW-1:0] LAST_RST = IW'(NUM_MASTERS - 1);
  localparam logic [CW-1:0] TO_VAL   = CW'(TIMEOUT);

  typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d;
  logic [IW-1:0]          gidx_q, gidx_d;   // index of the granted master
  logic [IW-1:0]          last_q, last_d;   // last master that owned the bus
  logic [CW-1:0]          cnt_q, cnt_d;     // silent-slave watchdog

  logic          found_s;
  logic [IW-1:0] next_idx_s;
  logic          g_cyc_s;
  logic          g_stb_s;
  logic          resp_s;
  logic          timeout_s;

  // Round-robin search starting one past the last owner.
  always_comb begin
    found_s    = 1'b0;
    next_idx_s = last_q;
    for (int k = 1; k <= NUM_MASTERS; k++) begin
      if (!found_s && wbm_cyc_i[(int'(last_q) + k) % NUM_MASTERS]) begin
        found_s    = 1'b1;
        next_idx_s = IW'((int'(last_q) + k) % NUM_MASTERS);
      end else begin
        found_s    = found_s;
      end
    end
  end

  assign g_cyc_s   = wbm_cyc_i[gidx_q];
  assign g_stb_s   = wbm_stb_i[gidx_q];
  assign resp_s    = wbs_ack_i | wbs_err_i | wbs_rty_i;
  // The watchdog only fires while a transfer is owned; it is cleared in IDLE.
  assign timeout_s = (state_q == BUSY) && (cnt_q == TO_VAL);

  // Next-state logic for arbitration FSM and watchdog.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    gidx_d  = gidx_q;
    last_d  = last_q;
    cnt_d   = {CW{1'b0}};
    case (state_q)
      IDLE: begin
        if (found_s) begin
          state_d = BUSY;
          gidx_d  = next_idx_s;
          for (int i = 0; i < NUM_MASTERS; i++) begin
            grant_d[i] = (next_idx_s == IW'(i));
          end
        end else begin
          grant_d = {NUM_MASTERS{1'b0}};
        end
      end
      BUSY: begin
        if (!g_cyc_s) begin
          state_d = IDLE;
          grant_d = {NUM_MASTERS{1'b0}};
          last_d  = gidx_q;
        end else if (resp_s || timeout_s) begin
          cnt_d   = {CW{1'b0}};
        end else if (g_stb_s) begin
          cnt_d   = cnt_q + CW'(1);
        end else begin
          cnt_d   = cnt_q;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = {NUM_MASTERS{1'b0}};
      end
    endcase
  end

  // State registers; reset parks the pointer so master 0 wins first.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
      grant_q <= {NUM_MASTERS{1'b0}};
      gidx_q  <= LAST_RST;
      last_q  <= LAST_RST;
      cnt_q   <= {CW{1'b0}};
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Slave request mux: only the granted master's strobe can reach the slave.
  always_comb begin
    wbs_adr_o = wbm_adr_i[gidx_q*aw +: aw];
    wbs_dat_o = wbm_dat_i[gidx_q*dw +: dw];
    wbs_sel_o = wbm_sel_i[gidx_q*4 +: 4];
    wbs_we_o  = wbm_we_i[gidx_q];
    wbs_cti_o = wbm_cti_i[gidx_q*3 +: 3];
    wbs_bte_o = wbm_bte_i[gidx_q*2 +: 2];
    if (state_q == BUSY) begin
      wbs_cyc_o = g_cyc_s;
      wbs_stb_o = g_stb_s & ~timeout_s;
    end else begin
      wbs_cyc_o = 1'b0;
      wbs_stb_o = 1'b0;
    end
  end

  // Termination routing back to the granted master only.
  always_comb begin
    wbm_ack_o = {NUM_MASTERS{1'b0}};
    wbm_err_o = {NUM_MASTERS{1'b0}};
    wbm_rty_o = {NUM_MASTERS{1'b0}};
    if (state_q == BUSY) begin
      wbm_ack_o[gidx_q] = wbs_ack_i & ~timeout_s;
      wbm_err_o[gidx_q] = wbs_err_i | timeout_s;
      wbm_rty_o[gidx_q] = wbs_rty_i & ~timeout_s;
    end else begin
      wbm_ack_o = {NUM_MASTERS{1'b0}};
    end
  end

  assign wbm_dat_o = wbs_dat_i;
  assign grant_o   = grant_q;

endmodule

// File: tb/tb_wb_ram_arbiter.sv
// Directed bench for wb_ram_arbiter (3 masters, 32-bit, TIMEOUT 255).
module tb_wb_ram_arbiter;

  logic        clk;
  logic        rst;
  logic [95:0] m_adr;
  logic [95:0] m_dat;
  logic [11:0] m_sel;
  logic [2:0]  m_we;
  logic [2:0]  m_cyc;
  logic [2:0]  m_stb;
  logic [8:0]  m_cti;
  logic [5:0]  m_bte;
  logic [31:0] m_dat_o;
  logic [2:0]  ack_o, err_o, rty_o, grant;
  logic [31:0] s_adr, s_dat;
  logic [3:0]  s_sel;
  logic        s_we, s_cyc, s_stb;
  logic [2:0]  s_cti;
  logic [1:0]  s_bte;
  logic        s_ack, s_err, s_rty;
  logic        ack_en;

  int n_cmp;
  int n_err;

  localparam logic [31:0] A0 = 32'h0000_1000;
  localparam logic [31:0] A1 = 32'h0000_2000;
  localparam logic [31:0] A2 = 32'h0000_3000;
  localparam logic [31:0] RD = 32'hCAFE_F00D;

  wb_ram_arbiter #(.NUM_MASTERS(3), .aw(32), .dw(32), .TIMEOUT(255)) dut (
    .wb_clk_i (clk),   .wb_rst_i (rst),
    .wbm_adr_i(m_adr), .wbm_dat_i(m_dat), .wbm_sel_i(m_sel),
    .wbm_we_i (m_we),  .wbm_cyc_i(m_cyc), .wbm_stb_i(m_stb),
    .wbm_cti_i(m_cti), .wbm_bte_i(m_bte),
    .wbm_dat_o(m_dat_o), .wbm_ack_o(ack_o), .wbm_err_o(err_o), .wbm_rty_o(rty_o),
    .wbs_adr_o(s_adr), .wbs_dat_o(s_dat), .wbs_sel_o(s_sel), .wbs_we_o(s_we),
    .wbs_cyc_o(s_cyc), .wbs_stb_o(s_stb), .wbs_cti_o(s_cti), .wbs_bte_o(s_bte),
    .wbs_dat_i(RD),    .wbs_ack_i(s_ack), .wbs_err_i(s_err), .wbs_rty_i(s_rty),
    .grant_o  (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Slave that acks every strobe when enabled.
  assign s_ack = ack_en & s_stb;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m(input int n, input logic c, input logic s, input logic w,
                       input logic [31:0] a, input logic [2:0] t);
    m_cyc[n]          = c;
    m_stb[n]          = s;
    m_we[n]           = w;
    m_adr[n*32 +: 32] = a;
    m_dat[n*32 +: 32] = a ^ 32'hFFFF_0000;
    m_sel[n*4 +: 4]   = 4'hF;
    m_cti[n*3 +: 3]   = t;
    m_bte[n*2 +: 2]   = 2'b00;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    n_cmp = 0; n_err = 0;
    rst = 1'b1; ack_en = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    m_adr = '0; m_dat = '0; m_sel = '0; m_we = '0; m_cyc = '0; m_stb = '0;
    m_cti = '0; m_bte = '0;
    #2;
    chk("rst_grant", grant, 3'b000);
    chk("rst_scyc", s_cyc, 1'b0);
    chk("rst_sstb", s_stb, 1'b0);
    chk("rst_ack", ack_o, 3'b000);
    chk("rst_err", err_o, 3'b000);
    chk("rst_rty", rty_o, 3'b000);
    step(); step();

    // Three simultaneous requesters, slave acks every cycle
    rst = 1'b0; ack_en = 1'b1;
    set_m(0, 1'b1, 1'b1, 1'b0, A0, 3'b000);
    set_m(1, 1'b1, 1'b1, 1'b0, A1, 3'b000);
    set_m(2, 1'b1, 1'b1, 1'b0, A2, 3'b000);
    #1;
    chk("rr_idle_grant", grant, 3'b000);
    chk("rr_idle_scyc", s_cyc, 1'b0);
    step();
    chk("rr_g0", grant, 3'b001);
    chk("rr_g0_adr", s_adr, A0);
    chk("rr_g0_ack", ack_o, 3'b001);
    chk("rr_dat_bcast", m_dat_o, RD);
    step(); set_m(0, 1'b0, 1'b0, 1'b0, A0, 3'b000); #1;
    chk("rr_g0_hold", grant, 3'b001);
    chk("rr_g0_drop_scyc", s_cyc, 1'b0);
    chk("rr_g0_drop_ack", ack_o, 3'b000);
    step();
    chk("rr_gap1", grant, 3'b000);
    step();
    chk("rr_g1", grant, 3'b010);
    chk("rr_g1_adr", s_adr, A1);
    chk("rr_g1_ack", ack_o, 3'b010);
    step(); set_m(1, 1'b0, 1'b0, 1'b0, A1, 3'b000);
    step();
    chk("rr_gap2", grant, 3'b000);
    step();
    chk("rr_g2", grant, 3'b100);
    chk("rr_g2_adr", s_adr, A2);
    chk("rr_g2_ack", ack_o, 3'b100);
    step(); set_m(2, 1'b0, 1'b0, 1'b0, A2, 3'b000);
    step();
    chk("rr_gap3", grant, 3'b000);
    step();
    chk("rr_none", grant, 3'b000);

    // Master 1 burst, master 0 waits behind it
    set_m(1, 1'b1, 1'b1, 1'b0, A1, 3'b010);
    step();
    chk("bu_g1", grant, 3'b010);
    set_m(0, 1'b1, 1'b1, 1'b0, A0, 3'b000);
    for (int b = 0; b < 4; b++) begin
      if (b > 0) begin
        step();
        set_m(1, 1'b1, 1'b1, 1'b0, A1 + 32'(b * 4), (b == 3) ? 3'b111 : 3'b010);
      end
      #1;
      chk("bu_grant", grant, 3'b010);
      chk("bu_ack", ack_o, 3'b010);
      chk("bu_adr", s_adr, A1 + 32'(b * 4));
      chk("bu_cti", s_cti, (b == 3) ? 3'b111 : 3'b010);
    end
    step(); set_m(1, 1'b0, 1'b0, 1'b0, A1, 3'b000); #1;
    chk("bu_drop_stb", s_stb, 1'b0);
    chk("bu_drop_ack", ack_o, 3'b000);
    step();
    chk("bu_gap", grant, 3'b000);
    step();
    chk("bu_g0", grant, 3'b001);
    chk("bu_g0_adr", s_adr, A0);
    step(); set_m(0, 1'b0, 1'b0, 1'b0, A0, 3'b000);
    step(); step();

    // err then rty to master 0 while master 1 is pending
    ack_en = 1'b0;
    set_m(0, 1'b1, 1'b1, 1'b0, A0, 3'b000);
    step();
    chk("er_g0", grant, 3'b001);
    set_m(1, 1'b1, 1'b1, 1'b1, A1, 3'b000);
    s_err = 1'b1;
    #1;
    chk("er_err", err_o, 3'b001);
    chk("er_rty", rty_o, 3'b000);
    chk("er_ack", ack_o, 3'b000);
    chk("er_adr", s_adr, A0);
    chk("er_we", s_we, 1'b0);
    step(); s_err = 1'b0; s_rty = 1'b1; #1;
    chk("ry_rty", rty_o, 3'b001);
    chk("ry_err", err_o, 3'b000);
    chk("ry_adr", s_adr, A0);
    step(); s_rty = 1'b0; set_m(0, 1'b0, 1'b0, 1'b0, A0, 3'b000); #1;
    chk("ry_drop_stb", s_stb, 1'b0);
    chk("ry_drop_err", err_o, 3'b000);
    step();
    chk("ry_gap", grant, 3'b000);
    step();
    chk("ry_g1", grant, 3'b010);

    // Asynchronous reset in the middle of master 1's burst
    ack_en = 1'b1;
    set_m(1, 1'b1, 1'b1, 1'b0, A1, 3'b010);
    set_m(0, 1'b1, 1'b1, 1'b0, A0, 3'b000);
    #1;
    chk("ar_pre_scyc", s_cyc, 1'b1);
    #3; rst = 1'b1; #1;
    chk("ar_scyc", s_cyc, 1'b0);
    chk("ar_sstb", s_stb, 1'b0);
    chk("ar_grant", grant, 3'b000);
    chk("ar_ack", ack_o, 3'b000);
    step(); rst = 1'b0; #1;
    chk("ar_idle", grant, 3'b000);
    step();
    chk("ar_g0", grant, 3'b001);
    chk("ar_g0_adr", s_adr, A0);
    set_m(0, 1'b0, 1'b0, 1'b0, A0, 3'b000);
    set_m(1, 1'b0, 1'b0, 1'b0, A1, 3'b000);
    step(); step(); step();

    // Master 2 write to a silent slave: one error pulse at 255 cycles
    ack_en = 1'b0;
    set_m(2, 1'b1, 1'b1, 1'b1, A2, 3'b000);
    step();
    chk("to_g2", grant, 3'b100);
    chk("to_we", s_we, 1'b1);
    chk("to_dat", s_dat, A2 ^ 32'hFFFF_0000);
    chk("to_c0_stb", s_stb, 1'b1);
    chk("to_c0_err", err_o, 3'b000);
    for (int i = 1; i < 255; i++) begin
      step();
      chk("to_early_err", err_o, 3'b000);
    end
    step();
    chk("to_err", err_o, 3'b100);
    chk("to_stb_low", s_stb, 1'b0);
    chk("to_ack", ack_o, 3'b000);
    step();
    chk("to_err_once", err_o, 3'b000);
    chk("to_stb_back", s_stb, 1'b1);
    set_m(2, 1'b0, 1'b0, 1'b0, A2, 3'b000);
    step(); step();
    chk("to_end_idle", grant, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
